// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave datapath.
package i2c_pkg;

   typedef enum logic [2:0] {IDLE, DATA, ACK_SETUP, ACK_HIGH, ACK_LOW} timer_state_t;

   localparam int I2C_BYTE_BITS = 8;
   localparam int I2C_BITCNT_W  = 4;

   // Bundle of the one-cycle strobes issued by the bit/byte timer.
   typedef struct packed {
      logic rx_shift;
      logic tx_shift;
      logic byte_received;
      logic ack_prep;
      logic ack_check;
      logic ack_done;
   } strobe_t;

endpackage

// File: rtl/i2c_bit_counter.sv
// Bit counter with synchronous clear, count enable and a terminal-value flag.
module i2c_bit_counter
   import i2c_pkg::*;
#(
   parameter int W = I2C_BITCNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         last
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == limit) ? '0 : count + 1'b1;
      end
   end

   // High when the next increment reaches the terminal value.
   assign last = (count == limit - 1'b1);

endmodule

// File: rtl/i2c_slave_timer.sv
// Bit/byte sequencer: turns synchronized SCL edges between START and STOP into
// registered one-cycle shift and ACK strobes for the slave controller.
module i2c_slave_timer
   import i2c_pkg::*;
#(
   parameter int BYTE_BITS = I2C_BYTE_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    scl_rise,
   input  logic                    scl_fall,
   output logic                    rx_shift,
   output logic                    tx_shift,
   output logic                    byte_received,
   output logic                    ack_prep,
   output logic                    ack_check,
   output logic                    ack_done,
   output logic [I2C_BITCNT_W-1:0] bit_count,
   output logic                    active
);

   localparam logic [I2C_BITCNT_W-1:0] LIMIT = I2C_BITCNT_W'(BYTE_BITS);

   timer_state_t state, state_n;
   strobe_t      strobe, strobe_n;
   logic         active_n;
   logic         cnt_clear, cnt_enable, cnt_last;
   logic         rise, fall;

   // Coincident edges are a glitch and cancel each other.
   assign rise = scl_rise & ~scl_fall;
   assign fall = scl_fall & ~scl_rise;

   i2c_bit_counter #(.W(I2C_BITCNT_W)) u_bit_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .limit  (LIMIT),
      .count  (bit_count),
      .last   (cnt_last)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_n    = state;
      strobe_n   = '0;
      cnt_clear  = 1'b0;
      cnt_enable = 1'b0;
      if (stop) begin
         state_n   = IDLE;
         cnt_clear = 1'b1;
      end else if (start) begin
         state_n   = DATA;
         cnt_clear = 1'b1;
      end else begin
         case (state)
            DATA: begin
               if (rise) begin
                  strobe_n.rx_shift = 1'b1;
                  cnt_enable        = 1'b1;
                  if (cnt_last) begin
                     strobe_n.byte_received = 1'b1;
                     state_n                = ACK_SETUP;
                  end
               end else if (fall && bit_count != '0 && bit_count < LIMIT) begin
                  // The fall before the first rise belongs to the controller's bit-0 load.
                  strobe_n.tx_shift = 1'b1;
               end
            end
            ACK_SETUP: if (fall) begin
               strobe_n.ack_prep = 1'b1;
               state_n           = ACK_HIGH;
            end
            ACK_HIGH: if (rise) begin
               strobe_n.ack_check = 1'b1;
               state_n            = ACK_LOW;
            end
            ACK_LOW: if (fall) begin
               strobe_n.ack_done = 1'b1;
               cnt_clear         = 1'b1;
               state_n           = DATA;
            end
            default: state_n = IDLE;
         endcase
      end
      active_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         strobe <= '0;
         active <= 1'b0;
      end else begin
         state  <= state_n;
         strobe <= strobe_n;
         active <= active_n;
      end
   end

   assign rx_shift      = strobe.rx_shift;
   assign tx_shift      = strobe.tx_shift;
   assign byte_received = strobe.byte_received;
   assign ack_prep      = strobe.ack_prep;
   assign ack_check     = strobe.ack_check;
   assign ack_done      = strobe.ack_done;

endmodule

// File: tb/tb_i2c_slave_timer.sv
// Directed self-checking bench for i2c_slave_timer with hand-computed expectations.
module tb_i2c_slave_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, scl_rise = 1'b0, scl_fall = 1'b0;
   logic       rx_shift, tx_shift, byte_received, ack_prep, ack_check, ack_done;
   logic [3:0] bit_count;
   logic       active;

   int checks = 0;
   int errors = 0;

   // Strobe vector order: {rx, tx, byte_received, ack_prep, ack_check, ack_done}
   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_RX   = 6'b100000;
   localparam logic [5:0] S_TX   = 6'b010000;
   localparam logic [5:0] S_BR   = 6'b001000;
   localparam logic [5:0] S_PREP = 6'b000100;
   localparam logic [5:0] S_CHK  = 6'b000010;
   localparam logic [5:0] S_DONE = 6'b000001;

   i2c_slave_timer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .scl_rise      (scl_rise),
      .scl_fall      (scl_fall),
      .rx_shift      (rx_shift),
      .tx_shift      (tx_shift),
      .byte_received (byte_received),
      .ack_prep      (ack_prep),
      .ack_check     (ack_check),
      .ack_done      (ack_done),
      .bit_count     (bit_count),
      .active        (active)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] strobes();
      return {rx_shift, tx_shift, byte_received, ack_prep, ack_check, ack_done};
   endfunction

   // One clock with the given input pulses; returns #1 after the edge, inputs cleared.
   task automatic cyc(input logic st, input logic sp, input logic r, input logic f);
      @(negedge clk);
      start = st; stop = sp; scl_rise = r; scl_fall = f;
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; scl_rise = 1'b0; scl_fall = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (strobes() !== S_NONE || bit_count !== 4'd0 || active !== 1'b0) begin
         errors++;
         $display("FAIL reset: strobes=%b bit_count=%0d active=%b, required 000000/0/0",
                  strobes(), bit_count, active);
      end
      @(negedge clk);
      rst = 1'b0;
      cyc(0, 0, 1, 0);
      checks++;
      if (strobes() !== S_NONE || active !== 1'b0) begin
         errors++;
         $display("FAIL idle_rise: strobes=%b active=%b, required 000000/0", strobes(), active);
      end
   endtask

   task automatic test_full_byte();
      cyc(1, 0, 0, 0);
      checks++;
      if (strobes() !== S_NONE || bit_count !== 4'd0 || active !== 1'b1) begin
         errors++;
         $display("FAIL start: strobes=%b bit_count=%0d active=%b, required 000000/0/1",
                  strobes(), bit_count, active);
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (strobes() !== S_NONE) begin
         errors++;
         $display("FAIL first_fall: strobes=%b, required 000000", strobes());
      end
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1, 0);
         checks++;
         if (strobes() !== ((i == 8) ? (S_RX | S_BR) : S_RX) || bit_count !== 4'(i)) begin
            errors++;
            $display("FAIL rise%0d: strobes=%b bit_count=%0d, required %b/%0d", i, strobes(),
                     bit_count, (i == 8) ? (S_RX | S_BR) : S_RX, i);
         end
         cyc(0, 0, 0, 1);
         checks++;
         if (strobes() !== ((i == 8) ? S_PREP : S_TX) || bit_count !== 4'(i)) begin
            errors++;
            $display("FAIL fall%0d: strobes=%b bit_count=%0d, required %b/%0d", i, strobes(),
                     bit_count, (i == 8) ? S_PREP : S_TX, i);
         end
      end
      cyc(0, 0, 1, 0);
      checks++;
      if (strobes() !== S_CHK || bit_count !== 4'd8) begin
         errors++;
         $display("FAIL ack_rise: strobes=%b bit_count=%0d, required %b/8", strobes(), bit_count, S_CHK);
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (strobes() !== S_NONE) begin
         errors++;
         $display("FAIL strobe_width: strobes=%b, required 000000", strobes());
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (strobes() !== S_DONE || bit_count !== 4'd0 || active !== 1'b1) begin
         errors++;
         $display("FAIL ack_fall: strobes=%b bit_count=%0d active=%b, required %b/0/1",
                  strobes(), bit_count, active, S_DONE);
      end
   endtask

   task automatic test_back_to_back();
      int n_rx = 0, n_br = 0, n_done = 0;
      cyc(1, 0, 0, 0);
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, 0);
            n_rx += int'(rx_shift); n_br += int'(byte_received); n_done += int'(ack_done);
            cyc(0, 0, 0, 1);
            n_rx += int'(rx_shift); n_br += int'(byte_received); n_done += int'(ack_done);
         end
      end
      checks++;
      if (n_rx != 16 || n_br != 2 || n_done != 2) begin
         errors++;
         $display("FAIL two_bytes_counts: rx=%0d br=%0d done=%0d, required 16/2/2", n_rx, n_br, n_done);
      end
      cyc(0, 1, 0, 0);
      checks++;
      if (active !== 1'b0 || bit_count !== 4'd0 || strobes() !== S_NONE) begin
         errors++;
         $display("FAIL stop_after_bytes: active=%b bit_count=%0d strobes=%b, required 0/0/000000",
                  active, bit_count, strobes());
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0);
         cyc(0, 0, 0, 1);
         checks++;
         if (strobes() !== S_NONE || active !== 1'b0) begin
            errors++;
            $display("FAIL post_stop_edges%0d: strobes=%b active=%b, required 000000/0",
                     i, strobes(), active);
         end
      end
   endtask

   task automatic test_repeated_start();
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1, 0);
         cyc(0, 0, 0, 1);
      end
      checks++;
      if (bit_count !== 4'd5) begin
         errors++;
         $display("FAIL pre_restart_count: bit_count=%0d, required 5", bit_count);
      end
      cyc(1, 0, 1, 0);
      checks++;
      if (bit_count !== 4'd0 || strobes() !== S_NONE || active !== 1'b1) begin
         errors++;
         $display("FAIL restart: bit_count=%0d strobes=%b active=%b, required 0/000000/1",
                  bit_count, strobes(), active);
      end
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1, 0);
         checks++;
         if (byte_received !== (i == 8)) begin
            errors++;
            $display("FAIL restart_rise%0d: byte_received=%b, required %b", i, byte_received, i == 8);
         end
         cyc(0, 0, 0, 1);
      end
      cyc(0, 1, 0, 0);
   endtask

   task automatic test_stop_mid_byte();
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0);
         cyc(0, 0, 0, 1);
      end
      cyc(0, 1, 0, 0);
      checks++;
      if (bit_count !== 4'd0 || active !== 1'b0 || strobes() !== S_NONE) begin
         errors++;
         $display("FAIL stop_mid: bit_count=%0d active=%b strobes=%b, required 0/0/000000",
                  bit_count, active, strobes());
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0);
         checks++;
         if (strobes() !== S_NONE || active !== 1'b0 || bit_count !== 4'd0) begin
            errors++;
            $display("FAIL stop_mid_edges%0d: strobes=%b active=%b bit_count=%0d, required 000000/0/0",
                     i, strobes(), active, bit_count);
         end
         cyc(0, 0, 0, 1);
      end
      cyc(1, 0, 0, 0);
      for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 0);
      checks++;
      if (strobes() !== (S_RX | S_BR) || bit_count !== 4'd8) begin
         errors++;
         $display("FAIL stop_mid_rebyte: strobes=%b bit_count=%0d, required %b/8",
                  strobes(), bit_count, S_RX | S_BR);
      end
   endtask

   task automatic test_async_reset();
      // Continues from the previous byte: 8th rise done, now in ACK_SETUP.
      cyc(0, 0, 0, 1);
      checks++;
      if (strobes() !== S_PREP) begin
         errors++;
         $display("FAIL ack_setup_fall: strobes=%b, required %b", strobes(), S_PREP);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (strobes() !== S_NONE || bit_count !== 4'd0 || active !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: strobes=%b bit_count=%0d active=%b, required 000000/0/0",
                  strobes(), bit_count, active);
      end
      @(negedge clk);
      rst = 1'b0;
      cyc(0, 0, 1, 0);
      checks++;
      if (strobes() !== S_NONE || active !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_rise: strobes=%b active=%b, required 000000/0", strobes(), active);
      end
   endtask

   task automatic test_simultaneous();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);
      checks++;
      if (bit_count !== 4'd2 || strobes() !== S_NONE) begin
         errors++;
         $display("FAIL glitch: bit_count=%0d strobes=%b, required 2/000000", bit_count, strobes());
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (strobes() !== S_TX || bit_count !== 4'd2) begin
         errors++;
         $display("FAIL post_glitch_fall: strobes=%b bit_count=%0d, required %b/2",
                  strobes(), bit_count, S_TX);
      end
      cyc(1, 1, 0, 0);
      checks++;
      if (active !== 1'b0 || bit_count !== 4'd0 || strobes() !== S_NONE) begin
         errors++;
         $display("FAIL start_stop: active=%b bit_count=%0d strobes=%b, required 0/0/000000",
                  active, bit_count, strobes());
      end
      cyc(0, 0, 1, 0);
      checks++;
      if (strobes() !== S_NONE || active !== 1'b0) begin
         errors++;
         $display("FAIL start_stop_idle: strobes=%b active=%b, required 000000/0", strobes(), active);
      end
   endtask

   initial begin
      test_reset();
      test_full_byte();
      test_back_to_back();
      test_repeated_start();
      test_stop_mid_byte();
      test_async_reset();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_timer.md
# i2c_slave_timer

Bit/byte sequencer for the I2C slave datapath. Counts synchronized SCL edges between START and STOP and issues one-cycle strobes: RX shift and TX shift per bit, byte_received after the last data bit, then ack_prep, ack_check and ack_done around the 9th (ACK) clock. It sits between the SCL edge detector and the slave controller and shift registers, and is the only source of those strobes.

## Interface
- BYTE_BITS, 8, data bits per byte before the ACK clock; legal range 2..15
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, START or repeated START detected
- stop  in  1  one-cycle pulse, STOP detected
- scl_rise  in  1  one-cycle pulse, synchronized SCL rising edge
- scl_fall  in  1  one-cycle pulse, synchronized SCL falling edge
- rx_shift  out  1  pulse: sample SDA into RX shift register
- tx_shift  out  1  pulse: advance TX shift register to next bit
- byte_received  out  1  pulse: BYTE_BITS data bits sampled
- ack_prep  out  1  pulse: ACK bit period begins, ACK driver set up
- ack_check  out  1  pulse: ACK bit sampled, SDA valid for ACK read
- ack_done  out  1  pulse: ACK clock ended, next byte begins
- bit_count  out  4  data bits sampled in current byte, 0..BYTE_BITS
- active  out  1  high from START until STOP

## Operation
- States: IDLE, DATA, ACK_SETUP, ACK_HIGH, ACK_LOW.
- IDLE: ignores edges. start: go to DATA, bit_count=0, active=1.
- DATA, on scl_rise:
  - rx_shift=1, bit_count+1.
  - If bit_count becomes BYTE_BITS: byte_received=1, go to ACK_SETUP.
- DATA, on scl_fall:
  - tx_shift=1 only when 1 ≤ bit_count ≤ BYTE_BITS-1.
  - The fall before the first rise (after START or ack_done) is ignored; bit 0 is loaded by the controller.
- ACK_SETUP: scl_fall gives ack_prep=1, go to ACK_HIGH.
- ACK_HIGH: scl_rise gives ack_check=1, go to ACK_LOW.
- ACK_LOW: scl_fall gives ack_done=1, bit_count=0, go to DATA.
- stop in any state: go to IDLE, bit_count=0, active=0, and no strobe that cycle.
- start in any non-IDLE state (repeated START): go to DATA, bit_count=0, and no strobe that cycle.
- stop and start in the same cycle: stop wins.
- scl_rise and scl_fall in the same cycle: both ignored (glitch); no state change, no strobe.
- Edge pulses arriving in a state that does not consume them are ignored.

## Timing
- All outputs are registered.
- Each strobe is exactly one cycle wide, asserted in the cycle after the input pulse that causes it.
- At most one of rx_shift, tx_shift, ack_prep, ack_check and ack_done is high in any cycle. byte_received is always coincident with the BYTE_BITS-th rx_shift.
- bit_count and active update in the same cycle as the strobe, one cycle after the triggering input.
- Reset, asynchronous: state=IDLE and every output 0, including bit_count=0 and active=0.
  - Reset mid-byte discards the partial count.
  - The first action after reset release requires start.
- Back-to-back edge pulses in consecutive cycles are each honoured. No minimum spacing beyond one cycle.

## Structure
- Shared package i2c_pkg holds:
  - typedef enum logic [2:0] timer_state_t {IDLE, DATA, ACK_SETUP, ACK_HIGH, ACK_LOW}
  - localparam I2C_BYTE_BITS = 8
  - localparam I2C_BITCNT_W = 4
- One sub-module, i2c_bit_counter: counter with synchronous clear, count enable and rollover flag at a programmable value. It holds bit_count and raises the terminal flag that produces byte_received.
- The FSM and output registers live in the top.

## Test plan
- Full byte, write direction: start, then 8×(rise, fall).
  - rx_shift ×8, with bit_count stepping 1..8.
  - byte_received with the 8th rx_shift.
  - tx_shift ×7, one per fall after rises 1..7.
  - The 8th fall gives ack_prep; the 9th rise gives ack_check; the 9th fall gives ack_done and bit_count=0.
- Two consecutive bytes followed by stop:
  - Exactly 16 rx_shift, 2 byte_received and 2 ack_done.
  - active drops one cycle after stop; all strobes stay 0 afterwards.
- Repeated START after 5 rises: bit_count=0 the cycle after start, no strobe; the next 8 rises produce byte_received.
- Stop at bit_count=3, then edges without start: no strobes and active=0. Then start and 8 rises: byte_received.
- rst asserted asynchronously during ACK_HIGH: all outputs 0 immediately (before the next clk edge). After release, scl_rise without start produces no ack_check.
- Simultaneous inputs:
  - scl_rise with scl_fall in DATA with bit_count=2: bit_count stays 2, no strobes.
  - start with stop: state is IDLE, active=0.
